icache_way_port_ctrl: RTL and testbench

//  Sequences and shares the single port of one sram_l1_icache_way macro (128 x 64b, byte wmask).

---
 rtl/icache_pkg.sv | 13 +
 rtl/icache_way_port_ctrl.sv | 95 +++++++++
 tb/tb_icache_way_port_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants and state encoding for the icache way port controller
package icache_pkg;
    localparam int ADDR_WIDTH   = 7;
    localparam int DATA_WIDTH   = 64;
    localparam int NUM_WMASKS   = 8;
    localparam int MAX_WR_BURST = 4;
    localparam int STREAK_WIDTH = $clog2(MAX_WR_BURST + 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;
endpackage

// File: rtl/icache_way_port_ctrl.sv
// rtl/icache_way_port_ctrl.sv - shares one icache way SRAM port between fetch, refill and clear sweep
module icache_way_port_ctrl
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req,
    output logic                  flush_busy,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  refill_req,
    input  logic [ADDR_WIDTH-1:0] refill_addr,
    input  logic [NUM_WMASKS-1:0] refill_wmask,
    input  logic [DATA_WIDTH-1:0] refill_data,
    output logic                  refill_gnt,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);
    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [STREAK_WIDTH-1:0] wr_streak;
    logic [1:0]              rd_pipe;
    logic                    streak_full;

    assign streak_full  = (wr_streak == STREAK_WIDTH'(MAX_WR_BURST));
    assign flush_busy   = rst || (state == CLEAR);
    assign fetch_rvalid = rd_pipe[1] && !rst;
    assign fetch_rdata  = sram_dout0;

    // The macro registers these signals itself, so they are driven straight from state + requests.
    always_comb begin
        refill_gnt  = 1'b0;
        fetch_gnt   = 1'b0;
        sram_csb0   = 1'b1;
        sram_web0   = 1'b0;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                sram_csb0   = 1'b0;
                sram_wmask0 = '1;
                sram_addr0  = clr_addr;
            end else if (refill_req && !(fetch_req && streak_full)) begin
                refill_gnt  = 1'b1;
                sram_csb0   = 1'b0;
                sram_wmask0 = refill_wmask;
                sram_addr0  = refill_addr;
                sram_din0   = refill_data;
            end else if (fetch_req) begin
                fetch_gnt   = 1'b1;
                sram_csb0   = 1'b0;
                sram_web0   = 1'b1;
                sram_addr0  = fetch_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            wr_streak <= '0;
            rd_pipe   <= '0;
        end else begin
            // The read pipe keeps moving during a sweep so reads granted before a flush complete.
            rd_pipe <= {rd_pipe[0], fetch_gnt};
            if (fetch_req && refill_gnt)
                wr_streak <= wr_streak + 1'b1;
            else
                wr_streak <= '0;
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1)
                        state <= RUN;
                end
                RUN: begin
                    if (flush_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_way_port_ctrl.sv
// tb/tb_icache_way_port_ctrl.sv - self-checking bench for icache_way_port_ctrl with a behavioural SRAM
module tb_icache_way_port_ctrl;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_req = 1'b0;
    logic        flush_busy;
    logic        fetch_req = 1'b0;
    logic [6:0]  fetch_addr = '0;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [63:0] fetch_rdata;
    logic        refill_req = 1'b0;
    logic [6:0]  refill_addr = '0;
    logic [7:0]  refill_wmask = '0;
    logic [63:0] refill_data = '0;
    logic        refill_gnt;
    logic        sram_csb0;
    logic        sram_web0;
    logic [7:0]  sram_wmask0;
    logic [6:0]  sram_addr0;
    logic [63:0] sram_din0;
    logic [63:0] sram_dout0;

    icache_way_port_ctrl dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .flush_busy(flush_busy),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .refill_req(refill_req), .refill_addr(refill_addr), .refill_wmask(refill_wmask),
        .refill_data(refill_data), .refill_gnt(refill_gnt),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk = ~clk;

    // Behavioural macro: inputs registered at posedge, write commits at negedge, read data one edge later.
    logic [63:0] mem [128];
    logic        r_csb = 1'b1;
    logic        r_web = 1'b1;
    logic [7:0]  r_wmask = '0;
    logic [6:0]  r_addr = '0;
    logic [63:0] r_din = '0;
    always @(posedge clk) begin
        if (!r_csb && r_web) sram_dout0 <= mem[r_addr];
        else                 sram_dout0 <= 'x;
        r_csb   <= sram_csb0;
        r_web   <= sram_web0;
        r_wmask <= sram_wmask0;
        r_addr  <= sram_addr0;
        r_din   <= sram_din0;
    end
    always @(negedge clk) begin
        if (!r_csb && !r_web)
            for (int b = 0; b < 8; b++)
                if (r_wmask[b]) mem[r_addr][8*b +: 8] <= r_din[8*b +: 8];
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Scoreboard: expected read data from the bench's own memory image, pushed at grant, popped at rvalid.
    logic [63:0] ref_mem [128];
    logic [63:0] exp_q [$];
    int          gcyc_q [$];
    int          cyc = 0;
    logic        clear_now = 1'b0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (fetch_rvalid) begin
            if (exp_q.size() == 0) begin
                check("stray_rvalid", 64'(fetch_rvalid), 64'd0);
            end else begin
                logic [63:0] e;
                int g;
                e = exp_q.pop_front();
                g = gcyc_q.pop_front();
                check("sb_rdata", fetch_rdata, e);
                check("sb_latency", 64'(cyc - g), 64'd2);
            end
        end
        if (rst) begin
            exp_q.delete();
            gcyc_q.delete();
            for (int a = 0; a < 128; a++) ref_mem[a] = '0;
        end else begin
            if (refill_gnt)
                for (int b = 0; b < 8; b++)
                    if (refill_wmask[b]) ref_mem[refill_addr][8*b +: 8] = refill_data[8*b +: 8];
            if (fetch_gnt) begin
                exp_q.push_back(ref_mem[fetch_addr]);
                gcyc_q.push_back(cyc);
            end
            if (clear_now)
                for (int a = 0; a < 128; a++) ref_mem[a] = '0;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_refill(input logic [6:0] a, input logic [63:0] d, input logic [7:0] m);
        logic granted;
        refill_addr = a; refill_data = d; refill_wmask = m; refill_req = 1'b1;
        granted = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (refill_gnt) begin granted = 1'b1; break; end
        end
        check("refill_gnt_wait", 64'(granted), 64'd1);
        @(posedge clk); #1;
        refill_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [6:0] a);
        logic granted;
        fetch_addr = a; fetch_req = 1'b1;
        granted = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (fetch_gnt) begin granted = 1'b1; break; end
        end
        check("fetch_gnt_wait", 64'(granted), 64'd1);
        @(posedge clk); #1;
        fetch_req = 1'b0;
    endtask

    task automatic fetch_expect(input string name, input logic [6:0] a, input logic [63:0] exp);
        logic seen;
        do_fetch(a);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (fetch_rvalid) begin
                seen = 1'b1;
                check(name, fetch_rdata, exp);
                break;
            end
        end
        check("rvalid_wait", 64'(seen), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_sweep();
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            check("sweep", {43'd0, sram_csb0, sram_web0, sram_wmask0, sram_addr0, flush_busy,
                            refill_gnt, fetch_gnt, (sram_din0 == 64'd0)},
                           {43'd0, 1'b0, 1'b0, 8'hFF, 7'(i), 1'b1, 1'b0, 1'b0, 1'b1});
        end
        @(negedge clk);
        check("busy_end", 64'(flush_busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_rst_state(input string name);
        @(negedge clk);
        check(name, 64'({sram_csb0, refill_gnt, fetch_gnt, fetch_rvalid, flush_busy}), 64'b10001);
    endtask

    typedef struct {
        logic       rr;
        logic       fr;
        logic [6:0] ra;
        logic [6:0] fa;
        logic       erg;
        logic       efg;
    } vec_t;
    vec_t vq [$];

    task automatic add_vec(input logic rr, input logic fr, input logic erg, input logic efg);
        int i;
        i = vq.size();
        vq.push_back('{rr: rr, fr: fr, ra: 7'(20 + i), fa: 7'(20 + i % 4), erg: erg, efg: efg});
    endtask

    initial begin
        // Arbitration table: refill-only, fetch-only, idle, sustained contention, streak reset by fetch_req low.
        add_vec(1, 0, 1, 0); add_vec(1, 0, 1, 0); add_vec(0, 1, 0, 1); add_vec(0, 0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) add_vec(1, 1, 1, 0);
            add_vec(1, 1, 0, 1);
        end
        add_vec(1, 1, 1, 0); add_vec(1, 0, 1, 0);
        for (int k = 0; k < 4; k++) add_vec(1, 1, 1, 0);
        add_vec(1, 1, 0, 1);

        // Reset state with both requests pending.
        fetch_req = 1'b1; refill_req = 1'b1; flush_req = 1'b1;
        for (int k = 0; k < 3; k++) check_rst_state("rst_state");
        @(posedge clk); #1;
        fetch_req = 1'b0; refill_req = 1'b0; flush_req = 1'b0;
        rst = 1'b0;
        check_sweep();

        // Full write then read, partial mask on a cleared word.
        do_refill(7'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        fetch_expect("rd_addr5", 7'd5, 64'hDEADBEEF_CAFEF00D);
        do_refill(7'd9, 64'h12345678_9ABCDEFF, 8'h01);
        fetch_expect("rd_addr9_mask", 7'd9, 64'h00000000_000000FF);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            refill_req = vq[i].rr; fetch_req = vq[i].fr;
            refill_addr = vq[i].ra; fetch_addr = vq[i].fa;
            refill_wmask = 8'hFF; refill_data = {32'hA5A5_0000, 32'(i)};
            @(negedge clk);
            check($sformatf("arb_vec%0d", i),
                  64'({refill_gnt, fetch_gnt, sram_csb0, sram_web0, sram_addr0}),
                  64'({vq[i].erg, vq[i].efg, !(vq[i].erg || vq[i].efg), vq[i].efg,
                       vq[i].erg ? vq[i].ra : (vq[i].efg ? vq[i].fa : 7'd0)}));
        end
        @(posedge clk); #1;
        refill_req = 1'b0; fetch_req = 1'b0;
        for (int k = 0; k < 4; k++) @(posedge clk);
        #1;

        // Fetch granted, flush the next cycle: the read still completes, then the sweep blocks grants.
        do_fetch(7'd5);
        flush_req = 1'b1; clear_now = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        flush_req = 1'b0; clear_now = 1'b0;
        fetch_req = 1'b1; fetch_addr = 7'd5;
        refill_req = 1'b1; refill_addr = 7'd100; refill_wmask = 8'hFF; refill_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        check("flush_rvalid", 64'(fetch_rvalid), 64'd1);
        check("flush_rdata", fetch_rdata, 64'hDEADBEEF_CAFEF00D);
        begin
            int n;
            n = 0;
            while (flush_busy && n < 200) begin
                check("flush_no_gnt", 64'({refill_gnt, fetch_gnt}), 64'd0);
                n++;
                @(negedge clk);
            end
            check("flush_len", 64'(n), 64'd128);
        end
        @(posedge clk); #1;
        refill_req = 1'b0; fetch_req = 1'b0;
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        fetch_expect("post_flush5", 7'd5, 64'd0);
        fetch_expect("post_flush9", 7'd9, 64'd0);

        // Reset right after a fetch grant drops the read; reset mid-sweep restarts from address 0.
        do_fetch(7'd100);
        rst = 1'b1;
        check_rst_state("rst_run");
        check_rst_state("rst_run2");
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            logic hit;
            hit = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (flush_busy && sram_addr0 == 7'd60) begin hit = 1'b1; break; end
            end
            check("reach_addr60", 64'(hit), 64'd1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        check_rst_state("rst_sweep");
        @(posedge clk); #1;
        rst = 1'b0;
        check_sweep();
        fetch_expect("post_rst100", 7'd100, 64'd0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
